iterative_alu: RTL

Execute-stage ALU. It consumes the 3-bit ALUCtrl code from the ALU control decoder and the two 32-bit operands, and produces the result and Zero flag. AND, XOR, SLL, ADD, SUB and SRA complete in one cycle. MUL runs on an iterative shift-add datapath over several cycles, and a start/busy/done handshake exposes this to the pipeline control.

---
 rtl/iterative_alu.sv | 127 ++++++++++++
 1 files changed

// File: rtl/iterative_alu.sv
// Execute-stage ALU. Single-cycle logic/shift/add ops plus an iterative
// shift-add multiplier exposed through a start/busy/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepts start_i; single-cycle ops complete from here
// ST_MUL  | retiring BITS_PER_CYCLE multiplier bits per edge, LSB first
//
// BITS_PER_CYCLE must divide WIDTH (1, 2 or 4).
module iterative_alu #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SH_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] mul_next;

  assign shamt = data2_i[SH_W-1:0];

  // Single-cycle result; reserved code 111 falls through to zero.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_SLL:  alu_res = data1_i << shamt;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_SRA:  alu_res = $signed(data1_i) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Sum of multiplicand copies selected by this iteration's multiplier bits.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  assign mul_next = acc + partial;

  // Control FSM with registered outputs and multiplier datapath.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      data_o <= '0;
      Zero_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              mcand  <= data1_i;
              mplier <= data2_i;
              acc    <= '0;
              cnt    <= CNT_LAST;
              busy_o <= 1'b1;
              state  <= ST_MUL;
            end else begin
              data_o <= alu_res;
              Zero_o <= (alu_res == '0);
              done_o <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc    <= mul_next;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            data_o <= mul_next;
            Zero_o <= (mul_next == '0);
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
